gnr_node_sequencer: RTL and testbench

GNR_NODE_SEQUENCER -- requirements
Module: gnr_node_sequencer

---
 rtl/gnr_node_sequencer.sv | 166 ++++++++++++++++
 tb/tb_gnr_node_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/gnr_node_sequencer.sv
// Sequencer that drives a two-phase node through repeated update iterations
// until its outputs settle or an iteration limit is reached.
module gnr_node_sequencer #(
  parameter int ITER_W   = 16,
  parameter int STABLE_N = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              init_state_i,
  input  logic [ITER_W-1:0] max_iter_i,
  input  logic              proliferation_s0_i,
  input  logic              proliferation_s1_i,
  output logic              reset_nos_o,
  output logic              node_init_o,
  output logic              start_s0_o,
  output logic              start_s1_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              converged_o,
  output logic [ITER_W-1:0] iter_count_o,
  output logic              final_s0_o,
  output logic              final_s1_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_STEP_A,
    S_STEP_B,
    S_SAMPLE,
    S_DONE
  } state_e;

  localparam logic [3:0] STABLE_LIM = 4'(STABLE_N);

  state_e              state_q;
  logic                init_q;
  logic [ITER_W-1:0]   max_q;
  logic [ITER_W-1:0]   iter_q;
  logic [3:0]          stable_q;
  logic [1:0]          prev_q;
  logic [1:0]          final_q;
  logic                converged_q;
  logic                busy_q;
  logic                done_q;
  logic                reset_nos_q;
  logic                start_s0_q;
  logic                start_s1_q;

  logic [1:0]          capture_d;
  logic [ITER_W-1:0]   iter_d;
  logic [3:0]          stable_d;

  // Values the SAMPLE state commits; the exit decision looks at these so
  // the limit test always precedes any further increment.
  assign capture_d = {proliferation_s0_i, proliferation_s1_i};
  assign iter_d    = iter_q + ITER_W'(1);
  assign stable_d  = (capture_d != prev_q)   ? 4'd0     :
                     (stable_q == 4'hF)      ? stable_q :
                                               stable_q + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      init_q      <= 1'b0;
      max_q       <= '0;
      iter_q      <= '0;
      stable_q    <= '0;
      prev_q      <= '0;
      final_q     <= '0;
      converged_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      reset_nos_q <= 1'b0;
      start_s0_q  <= 1'b0;
      start_s1_q  <= 1'b0;
    end else begin
      // NOTE: pulses default low here and the case below overrides them;
      // with non-blocking assignments the last write in the block wins.
      done_q      <= 1'b0;
      reset_nos_q <= 1'b0;
      start_s0_q  <= 1'b0;
      start_s1_q  <= 1'b0;

      if (abort_i && state_q != S_IDLE) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start_i && !abort_i) begin
              init_q      <= init_state_i;
              max_q       <= max_iter_i;
              iter_q      <= '0;
              stable_q    <= '0;
              converged_q <= 1'b0;
              busy_q      <= 1'b1;
              reset_nos_q <= 1'b1;
              state_q     <= S_INIT;
            end
          end
          S_INIT: begin
            prev_q <= {init_q, init_q};
            if (max_q == '0) begin
              final_q <= {init_q, init_q};
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              start_s0_q <= 1'b1;
              start_s1_q <= 1'b1;
              state_q    <= S_STEP_A;
            end
          end
          S_STEP_A: begin
            // Second s0 pulse restores the node's two-phase gating.
            start_s0_q <= 1'b1;
            state_q    <= S_STEP_B;
          end
          S_STEP_B: begin
            state_q <= S_SAMPLE;
          end
          S_SAMPLE: begin
            final_q  <= capture_d;
            prev_q   <= capture_d;
            iter_q   <= iter_d;
            stable_q <= stable_d;
            if (stable_d == STABLE_LIM) begin
              converged_q <= 1'b1;
              done_q      <= 1'b1;
              state_q     <= S_DONE;
            end else if (iter_d == max_q) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              start_s0_q <= 1'b1;
              start_s1_q <= 1'b1;
              state_q    <= S_STEP_A;
            end
          end
          S_DONE: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign reset_nos_o  = reset_nos_q;
  assign node_init_o  = init_q;
  assign start_s0_o   = start_s0_q;
  assign start_s1_o   = start_s1_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign converged_o  = converged_q;
  assign iter_count_o = iter_q;
  assign final_s0_o   = final_q[1];
  assign final_s1_o   = final_q[0];

endmodule

// File: tb/tb_gnr_node_sequencer.sv
// Self-checking bench for gnr_node_sequencer: a table of runs scored through
// a queue at the done pulse, plus hand-written abort and async-reset sequences.
module tb_gnr_node_sequencer;

  localparam int ITER_W = 16;

  logic              clk;
  logic              rst_n;
  logic              start_i;
  logic              abort_i;
  logic              init_state_i;
  logic [ITER_W-1:0] max_iter_i;
  logic              proliferation_s0_i;
  logic              proliferation_s1_i;
  logic              reset_nos_o;
  logic              node_init_o;
  logic              start_s0_o;
  logic              start_s1_o;
  logic              busy_o;
  logic              done_o;
  logic              converged_o;
  logic [ITER_W-1:0] iter_count_o;
  logic              final_s0_o;
  logic              final_s1_o;

  gnr_node_sequencer #(.ITER_W(ITER_W), .STABLE_N(4)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start_i            (start_i),
    .abort_i            (abort_i),
    .init_state_i       (init_state_i),
    .max_iter_i         (max_iter_i),
    .proliferation_s0_i (proliferation_s0_i),
    .proliferation_s1_i (proliferation_s1_i),
    .reset_nos_o        (reset_nos_o),
    .node_init_o        (node_init_o),
    .start_s0_o         (start_s0_o),
    .start_s1_o         (start_s1_o),
    .busy_o             (busy_o),
    .done_o             (done_o),
    .converged_o        (converged_o),
    .iter_count_o       (iter_count_o),
    .final_s0_o         (final_s0_o),
    .final_s1_o         (final_s1_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Node behaviour modes: 0 both low, 1 both toggle per iteration,
  // 2 s0 high / s1 low, 3 s0 high / s1 toggles.
  typedef struct {
    logic              init;
    logic [ITER_W-1:0] max_iter;
    int                mode;
    bit                poke;
    logic              conv;
    logic [ITER_W-1:0] iter;
    logic              f0;
    logic              f1;
    int                done_cyc;
  } vec_t;

  vec_t vecs[9];
  vec_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   mode   = 0;
  int   it_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_nodes();
    case (mode)
      0:       begin proliferation_s0_i = 1'b0; proliferation_s1_i = 1'b0;       end
      1:       begin proliferation_s0_i = it_cnt[0]; proliferation_s1_i = it_cnt[0]; end
      2:       begin proliferation_s0_i = 1'b1; proliferation_s1_i = 1'b0;       end
      default: begin proliferation_s0_i = 1'b1; proliferation_s1_i = it_cnt[0]; end
    endcase
  endtask

  task automatic do_run(input vec_t v, input int id);
    int   done_at;
    int   bad;
    bit   seen;
    vec_t e;
    logic [2:0] exp_sb;
    mode    = v.mode;
    it_cnt  = 0;
    drive_nodes();
    bad     = 0;
    seen    = 0;
    done_at = 0;
    @(negedge clk);
    init_state_i = v.init;
    max_iter_i   = v.max_iter;
    start_i      = 1'b1;
    sb_q.push_back(v);
    for (int cyc = 1; cyc <= 200 && !seen; cyc++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (node_init_o !== v.init || busy_o !== 1'b1) bad++;
      if (cyc == 1) begin
        if ({reset_nos_o, start_s0_o, start_s1_o} !== 3'b100) bad++;
      end else if (!done_o) begin
        case ((cyc - 2) % 3)
          0:       exp_sb = 3'b011;
          1:       exp_sb = 3'b010;
          default: exp_sb = 3'b000;
        endcase
        if ({reset_nos_o, start_s0_o, start_s1_o} !== exp_sb) bad++;
      end else begin
        if ({reset_nos_o, start_s0_o, start_s1_o} !== 3'b000) bad++;
      end
      if (start_s1_o) begin
        it_cnt++;
        drive_nodes();
      end
      if (v.poke && cyc == 3) begin
        start_i      = 1'b1;
        init_state_i = ~v.init;
        max_iter_i   = 16'd99;
      end
      if (done_o) begin
        seen    = 1;
        done_at = cyc;
      end
    end
    if (!seen) begin
      check($sformatf("v%0d_done_timeout", id), 32'd0, 32'd1);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end else begin
      e = sb_q.pop_front();
      check($sformatf("v%0d_done_cycle", id), done_at, e.done_cyc);
      check($sformatf("v%0d_converged", id), converged_o, e.conv);
      check($sformatf("v%0d_iter_count", id), iter_count_o, e.iter);
      check($sformatf("v%0d_final", id), {final_s0_o, final_s1_o}, {e.f0, e.f1});
      check($sformatf("v%0d_strobe_pattern_errs", id), bad, 0);
      @(negedge clk);
      check($sformatf("v%0d_hold_after_done", id),
            {busy_o, done_o, converged_o, iter_count_o, final_s0_o, final_s1_o},
            {1'b0, 1'b0, e.conv, e.iter, e.f0, e.f1});
    end
  endtask

  initial begin
    int done_seen;
    // init, max, mode, poke, conv, iter, f0, f1, done cycle
    vecs[0] = '{1'b0, 16'd5,  0, 1'b0, 1'b1, 16'd4, 1'b0, 1'b0, 14};
    vecs[1] = '{1'b0, 16'd3,  1, 1'b1, 1'b0, 16'd3, 1'b1, 1'b1, 11};
    vecs[2] = '{1'b1, 16'd0,  0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 2};
    vecs[3] = '{1'b1, 16'd10, 0, 1'b0, 1'b1, 16'd5, 1'b0, 1'b0, 17};
    vecs[4] = '{1'b0, 16'd7,  2, 1'b0, 1'b1, 16'd5, 1'b1, 1'b0, 17};
    vecs[5] = '{1'b0, 16'd6,  3, 1'b0, 1'b0, 16'd6, 1'b1, 1'b0, 20};
    vecs[6] = '{1'b1, 16'd1,  0, 1'b0, 1'b0, 16'd1, 1'b0, 1'b0, 5};
    vecs[7] = '{1'b0, 16'd4,  0, 1'b0, 1'b1, 16'd4, 1'b0, 1'b0, 14};
    vecs[8] = '{1'b1, 16'd2,  2, 1'b0, 1'b0, 16'd2, 1'b1, 1'b0, 8};

    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0;
    init_state_i = 1'b0; max_iter_i = '0;
    proliferation_s0_i = 1'b0; proliferation_s1_i = 1'b0;
    #2;
    check("reset_outputs",
          {reset_nos_o, node_init_o, start_s0_o, start_s1_o, busy_o, done_o,
           converged_o, iter_count_o, final_s0_o, final_s1_o}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) do_run(vecs[i], i);

    // Abort during STEP_B of the second iteration.
    mode = 0; it_cnt = 0; drive_nodes();
    @(negedge clk);
    init_state_i = 1'b0; max_iter_i = 16'd5; start_i = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    check("abort_pre_step_b", {start_s0_o, start_s1_o, busy_o}, 3'b101);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("abort_idle_outputs",
          {reset_nos_o, start_s0_o, start_s1_o, busy_o, done_o}, 5'b00000);
    check("abort_iter_count", iter_count_o, 16'd1);
    check("abort_status_hold", {converged_o, final_s0_o, final_s1_o}, 3'b000);
    done_seen = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      if (done_o || busy_o) done_seen++;
    end
    check("abort_no_done", done_seen, 0);

    // Abort overrides start while idle.
    start_i = 1'b1; abort_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; abort_i = 1'b0;
    check("abort_beats_start", {busy_o, reset_nos_o}, 2'b00);
    do_run(vecs[0], 10);

    // Asynchronous reset while in STEP_A.
    mode = 0; it_cnt = 0; drive_nodes();
    @(negedge clk);
    init_state_i = 1'b1; max_iter_i = 16'd5; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    check("rst_pre_step_a", {start_s0_o, start_s1_o, busy_o, node_init_o}, 4'b1111);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {reset_nos_o, node_init_o, start_s0_o, start_s1_o, busy_o, done_o,
           converged_o, iter_count_o, final_s0_o, final_s1_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_run(vecs[0], 11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
